// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a toggle req/ack bus crossing.
// Holds one word on xfer_data while xfer_req toggles and ack returns.
module cdc_handshake_tx #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGE = 3,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter logic [WIDTH-1:0] RESET_INIT_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_sync,
  input  logic             rstn_sync,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TPRE = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SYNC_STAGE-1:0] r_ack_sync;
  logic [WIDTH-1:0]      r_data;
  logic                  r_req;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic                  r_err;
  logic                  w_ack_s;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_to_hit;

  assign w_ack_s = r_ack_sync[SYNC_STAGE-1];

  assign w_to_hit = (TIMEOUT_CYCLES != 0) &&
                    (r_state == WAIT_ACK) &&
                    (r_cnt == TPRE);

  // state register
  always_ff @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // accept in IDLE, finish once synced ack matches the request
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_ack_s == r_req) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // plain flop chain bringing xfer_ack into this domain
  always_ff @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) r_ack_sync <= '0;
    else r_ack_sync <= {r_ack_sync[SYNC_STAGE-2:0], xfer_ack};
  end

  // word and toggle change together, only on accept
  always_ff @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) begin
      r_data <= RESET_INIT_VALUE;
      r_req  <= 1'b0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_req  <= ~r_req;
    end
  end

  // wait-time counter, saturating
  always_ff @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == WAIT_ACK && r_cnt != TMAX) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // done pulse and sticky timeout flag (set beats clear)
  always_ff @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_complete;
      r_err  <= w_to_hit | (r_err & ~err_clr);
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state == WAIT_ACK);
  assign xfer_data   = r_data;
  assign xfer_req    = r_req;
  assign done        = r_done;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: vector table, corner sequences and a
// random run checked against a cycle-count reference model.
module tb_cdc_handshake_tx;

  localparam int W = 32;
  localparam int S = 3;
  localparam int T = 16;

  logic         clk_sync = 1'b0;
  logic         rstn_sync = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] xfer_data;
  logic         xfer_req;
  logic         xfer_ack = 1'b0;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic         err_clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_sync = ~clk_sync;

  cdc_handshake_tx #(
    .WIDTH(W),
    .SYNC_STAGE(S),
    .TIMEOUT_CYCLES(T),
    .RESET_INIT_VALUE({W{1'b0}})
  ) dut (
    .clk_sync(clk_sync),
    .rstn_sync(rstn_sync),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .xfer_data(xfer_data),
    .xfer_req(xfer_req),
    .xfer_ack(xfer_ack),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  typedef struct {
    logic         vld;
    logic [W-1:0] din;
    logic         ack;
    logic         clr;
    logic         e_rdy;
    logic         e_busy;
    logic         e_req;
    logic         e_done;
    logic         e_err;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t tbl[20];

  // reference model: ack history queue, cycle stamps
  logic         aq[$];
  logic         m_busy;
  logic         m_req;
  logic         m_done;
  logic         m_err;
  logic [W-1:0] m_data;
  int           m_cyc;
  int           m_acc;

  function automatic logic [63:0] pk(
    input logic r, input logic b, input logic q,
    input logic d, input logic e, input logic [W-1:0] dat);
    return {27'b0, r, b, q, d, e, dat};
  endfunction

  function automatic logic [63:0] dut_vec();
    return pk(in_ready, busy, xfer_req, done, timeout_err,
              xfer_data);
  endfunction

  function automatic vec_t mk(
    input logic vld, input logic [W-1:0] din,
    input logic ack, input logic clr,
    input logic r, input logic b, input logic q,
    input logic d, input logic e, input logic [W-1:0] dat);
    vec_t v;
    v.vld = vld; v.din = din; v.ack = ack; v.clr = clr;
    v.e_rdy = r; v.e_busy = b; v.e_req = q;
    v.e_done = d; v.e_err = e; v.e_data = dat;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    for (int i = 0; i < S; i++) aq.push_back(1'b0);
    m_busy = 1'b0;
    m_req  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_data = '0;
    m_cyc  = 0;
    m_acc  = 0;
  endtask

  task automatic model_edge();
    logic ack_s;
    logic set_err;
    set_err = 1'b0;
    ack_s = aq.pop_front();
    aq.push_back(xfer_ack);
    m_cyc++;
    m_done = 1'b0;
    if (m_busy) begin
      set_err = (T != 0) && (m_cyc - m_acc == T);
      if (ack_s == m_req) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_req  = ~m_req;
      m_data = in_data;
      m_acc  = m_cyc;
    end
    m_err = set_err | (m_err & ~err_clr);
  endtask

  task automatic step();
    @(posedge clk_sync);
    model_edge();
    @(negedge clk_sync);
    chk("model", dut_vec(),
        pk(!m_busy, m_busy, m_req, m_done, m_err, m_data));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset(input string tag);
    #2 rstn_sync = 1'b0;
    #1;
    chk({tag, "_now"}, dut_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    repeat (2) @(posedge clk_sync);
    @(negedge clk_sync);
    chk({tag, "_hold"}, dut_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    rstn_sync = 1'b1;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly;
    dly = 0;

    tbl[0] = mk(1'b1, 32'hA5A5_1234, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_1234);
    for (int i = 1; i < 13; i++)
      tbl[i] = mk(1'b1, 32'hC0DE_0000 + 32'(i), (i >= 10), 1'b0,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_1234);
    tbl[13] = mk(1'b1, 32'hC0DE_00FF, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5_1234);
    tbl[14] = mk(1'b1, 32'h0000_00FF, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00FF);
    for (int i = 15; i < 18; i++)
      tbl[i] = mk(1'b0, 32'hBEEF_0000 + 32'(i), 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00FF);
    tbl[18] = mk(1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00FF);
    tbl[19] = mk(1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00FF);

    @(negedge clk_sync);
    do_reset("rst_init");

    // single word, backpressure, back-to-back
    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].din;
      xfer_ack = tbl[i].ack;
      err_clr  = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i), dut_vec(),
          pk(tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_req,
             tbl[i].e_done, tbl[i].e_err, tbl[i].e_data));
    end

    // timeout, set beats clear, late ack, clear
    in_valid = 1'b1;
    in_data  = 32'h5A5A_0016;
    step();
    in_valid = 1'b0;
    chk("to_accept", {62'b0, busy, xfer_req}, 64'd3);
    for (int k = 1; k < T; k++) begin
      step();
      chk($sformatf("to_early%0d", k), {63'b0, timeout_err}, 64'd0);
    end
    err_clr = 1'b1;
    step();
    chk("to_set_wins", {63'b0, timeout_err}, 64'd1);
    err_clr = 1'b0;
    step();
    chk("to_sticky", {62'b0, timeout_err, busy}, 64'd3);
    xfer_ack = 1'b1;
    steps(3);
    chk("late_pre", {63'b0, done}, 64'd0);
    step();
    chk("late_done", {62'b0, done, timeout_err}, 64'd3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_clr", {63'b0, timeout_err}, 64'd0);

    // complete one more, then reset in the middle of the next
    in_valid = 1'b1;
    in_data  = 32'h0BAD_0001;
    step();
    in_valid = 1'b0;
    xfer_ack = 1'b0;
    steps(4);
    chk("w1_done", {63'b0, done}, 64'd1);
    in_valid = 1'b1;
    in_data  = 32'h0BAD_0002;
    step();
    in_valid = 1'b0;
    steps(2);
    chk("pre_rst", {62'b0, busy, xfer_req}, 64'd3);
    do_reset("rst_mid");

    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    chk("post_acc", dut_vec(),
        pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF));
    xfer_ack = 1'b1;
    steps(3);
    chk("post_pre", {63'b0, done}, 64'd0);
    step();
    chk("post_done", {63'b0, done}, 64'd1);

    // random traffic with a far-side responder of varying delay
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      err_clr  = ($urandom_range(0, 15) == 0);
      if (m_req != xfer_ack) begin
        if (dly == 0) xfer_ack = m_req;
        else dly--;
      end else begin
        dly = $urandom_range(0, 22);
      end
      if (!m_busy && $urandom_range(0, 99) == 0)
        xfer_ack = ~xfer_ack;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
